// File: rtl/fir_tdm_pkg.sv
// rtl/fir_tdm_pkg.sv - shared types, width helpers and constants for the TDM FIR filter
package fir_tdm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } fir_state_e;

  // Coefficient value loaded at reset; all-ones taps make a moving-sum filter.
  localparam int DEFAULT_COEF = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // A single channel still needs a one-bit channel field.
  function automatic int ch_width(input int channels);
    return (clog2(channels) < 1) ? 1 : clog2(channels);
  endfunction

  // Full-precision width: product width plus one bit per doubling of taps.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac.sv
// rtl/fir_mac.sv - shared signed multiply-accumulate unit
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   a, b       : signed sample and coefficient operands
//   clr        : zero the accumulator register
//   en         : add a*b into the accumulator register
//   acc        : running sum including this cycle's product when en=1
module fir_mac #(
  parameter int DATA_W = 14,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 34
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [COEF_W-1:0] b,
  input  logic                     clr,
  input  logic                     en,
  output logic signed [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int EXT_W  = ACC_W - PROD_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;

  assign prod     = a * b;
  assign prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};

  // Exposing the sum that includes the current product lets the caller
  // capture the final result on the same edge as the last tap.
  assign acc = acc_q + (en ? prod_ext : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else if (clr) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/fir_filter_tdm.sv
// rtl/fir_filter_tdm.sv - multi-channel time-multiplexed FIR filter with one shared MAC
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid/in_ready     : sample handshake; in_data signed sample, in_chan its channel
//   out_valid/out_ready   : result handshake; out_data signed full-precision sum, out_chan
//   coef_we/coef_addr/coef_data : coefficient write (tap 0 = newest sample)
//   coef_ready            : coefficient writes are honoured this cycle
//   err_chan              : one-cycle pulse when a sample for a nonexistent channel is dropped
module fir_filter_tdm
  import fir_tdm_pkg::*;
#(
  parameter int DATA_W   = 14,
  parameter int COEF_W   = 16,
  parameter int TAPS     = 16,
  parameter int CHANNELS = 2,
  localparam int CH_W    = ch_width(CHANNELS),
  localparam int TAP_W   = clog2(TAPS),
  localparam int ACC_W   = acc_width(DATA_W, COEF_W, TAPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CH_W-1:0]   in_chan,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic [CH_W-1:0]   out_chan,
  input  logic              coef_we,
  input  logic [TAP_W-1:0]  coef_addr,
  input  logic [COEF_W-1:0] coef_data,
  output logic              coef_ready,
  output logic              err_chan
);

  localparam logic [CH_W:0]    NUM_CH   = CHANNELS[CH_W:0];
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

  fir_state_e state, state_n;

  logic signed [DATA_W-1:0] dline [CHANNELS][TAPS];
  logic [TAP_W-1:0]         wptr  [CHANNELS];
  logic signed [COEF_W-1:0] coef  [TAPS];

  logic [CH_W-1:0]          cur_ch;
  logic [TAP_W-1:0]         cur_pos;
  logic [TAP_W-1:0]         tap;
  logic [TAP_W-1:0]         rd_idx;
  logic                     chan_ok;
  logic                     accept;
  logic                     mac_clr;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  mac_acc;

  // Widen by one bit so a power-of-two channel count does not truncate to 0.
  assign chan_ok = ({1'b0, in_chan} < NUM_CH);

  // x[n-k] lives k slots behind the slot the current sample was written to.
  always_comb begin
    if (cur_pos >= tap) rd_idx = cur_pos - tap;
    else                rd_idx = TAP_W'(int'(cur_pos) + TAPS - int'(tap));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    mac_clr = 1'b0;
    mac_en  = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready && chan_ok) begin
          accept  = 1'b1;
          mac_clr = 1'b1;
          state_n = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (tap == LAST_TAP) state_n = OUT;
      end
      OUT: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  fir_mac #(
    .DATA_W(DATA_W),
    .COEF_W(COEF_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk  (clk),
    .reset(reset),
    .a    (dline[cur_ch][rd_idx]),
    .b    (coef[tap]),
    .clr  (mac_clr),
    .en   (mac_en),
    .acc  (mac_acc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready   <= 1'b0;
      coef_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      err_chan   <= 1'b0;
      cur_ch     <= '0;
      cur_pos    <= '0;
      tap        <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        wptr[c] <= '0;
        for (int t = 0; t < TAPS; t++) dline[c][t] <= '0;
      end
      for (int t = 0; t < TAPS; t++) coef[t] <= COEF_W'(DEFAULT_COEF);
    end else begin
      in_ready   <= (state_n == IDLE);
      coef_ready <= (state_n == IDLE);
      err_chan   <= (state == IDLE) && in_valid && in_ready && !chan_ok;

      if (coef_ready && coef_we && (int'(coef_addr) < TAPS)) coef[coef_addr] <= coef_data;

      if (accept) begin
        dline[in_chan][wptr[in_chan]] <= in_data;
        wptr[in_chan] <= (wptr[in_chan] == LAST_TAP) ? '0 : wptr[in_chan] + TAP_W'(1);
        cur_pos <= wptr[in_chan];
        cur_ch  <= in_chan;
        tap     <= '0;
      end

      if (state == MAC) begin
        tap <= tap + TAP_W'(1);
        if (tap == LAST_TAP) begin
          out_data  <= mac_acc;
          out_chan  <= cur_ch;
          out_valid <= 1'b1;
        end
      end

      if (state == OUT && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_filter_tdm.sv
// tb/tb_fir_filter_tdm.sv - directed self-checking bench for fir_filter_tdm
module tb_fir_filter_tdm;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic [13:0]        in_data;
  logic [0:0]         in_chan, out_chan;
  logic signed [33:0] out_data;
  logic               coef_we, coef_ready, err_chan;
  logic [3:0]         coef_addr;
  logic [15:0]        coef_data;

  logic               e_in_valid, e_in_ready, e_out_valid, e_out_ready;
  logic [13:0]        e_in_data;
  logic [1:0]         e_in_chan, e_out_chan;
  logic signed [31:0] e_out_data;
  logic               e_coef_we, e_coef_ready, e_err_chan;
  logic [1:0]         e_coef_addr;
  logic [15:0]        e_coef_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;

  fir_filter_tdm dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chan(in_chan),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_ready(coef_ready), .err_chan(err_chan)
  );

  fir_filter_tdm #(.TAPS(4), .CHANNELS(3)) dut_e (
    .clk(clk), .reset(reset),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data), .in_chan(e_in_chan),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_data(e_out_data), .out_chan(e_out_chan),
    .coef_we(e_coef_we), .coef_addr(e_coef_addr), .coef_data(e_coef_data),
    .coef_ready(e_coef_ready), .err_chan(e_err_chan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0;
    e_in_valid = 1'b0; e_out_ready = 1'b0; e_coef_we = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = 4'(a); coef_data = 16'(v);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic send(input logic [0:0] ch, input int d);
    int n;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready wait", in_ready, 1);
    in_valid = 1'b1; in_chan = ch; in_data = 14'(d);
    @(negedge clk);
    in_valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic recv(input longint exp, input logic [0:0] ch, input string tag);
    int n;
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk({tag, " latency"}, cyc - t0, 16);
    chk({tag, " data"}, out_data, exp);
    chk({tag, " chan"}, out_chan, ch);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    longint e;
    in_data = '0; in_chan = '0; coef_addr = '0; coef_data = '0;
    e_in_data = '0; e_in_chan = '0; e_coef_addr = '0; e_coef_data = '0;
    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; coef_we = 1'b0;
    e_in_valid = 1'b0; e_out_ready = 1'b0; e_coef_we = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst in_ready", in_ready, 0);
    chk("rst coef_ready", coef_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_chan", out_chan, 0);
    chk("rst err_chan", err_chan, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post-rst in_ready", in_ready, 1);
    chk("post-rst coef_ready", coef_ready, 1);

    // Moving average with default coefficients
    for (int i = 0; i < 17; i++) begin
      e = (i < 16) ? (i + 1) * 100 : 1600;
      send(1'b0, 100);
      recv(e, 1'b0, $sformatf("ma%0d", i));
    end
    chk("main err quiet", err_chan, 0);

    // Impulse response with c[k] = k+1
    do_reset();
    for (int k = 0; k < 16; k++) write_coef(k, k + 1);
    send(1'b0, 1000);
    recv(1000, 1'b0, "imp0");
    for (int i = 1; i < 17; i++) begin
      e = (i < 16) ? (i + 1) * 1000 : 0;
      send(1'b0, 0);
      recv(e, 1'b0, $sformatf("imp%0d", i));
    end

    // Channel isolation
    do_reset();
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 1000);
      recv((i + 1) * 1000, 1'b0, $sformatf("iso0_%0d", i));
      send(1'b1, -1000);
      recv(-(i + 1) * 1000, 1'b1, $sformatf("iso1_%0d", i));
    end

    // Backpressure: result held, coefficient writes ignored while in OUT
    do_reset();
    send(1'b1, 50);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    chk("bp latency", cyc - t0, 16);
    for (int i = 0; i < 5; i++) begin
      coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'd7;
      @(negedge clk);
      chk($sformatf("bp hold data %0d", i), out_data, 50);
      chk($sformatf("bp hold chan %0d", i), out_chan, 1);
      chk($sformatf("bp hold valid %0d", i), out_valid, 1);
      chk($sformatf("bp in_ready %0d", i), in_ready, 0);
      chk($sformatf("bp coef_ready %0d", i), coef_ready, 0);
    end
    coef_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp released", out_valid, 0);
    send(1'b1, 50);
    recv(100, 1'b1, "bp ignored write");
    // Write in the same cycle as an accept is used by that sample
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 16'd7;
    send(1'b1, 50);
    coef_we = 1'b0;
    recv(450, 1'b1, "bp same-cycle write");

    // Full scale: -32768 * -8192 * 16 = 2^32
    do_reset();
    for (int k = 0; k < 16; k++) write_coef(k, -32768);
    for (int i = 0; i < 16; i++) begin
      e = longint'(i + 1) * 268435456;
      send(1'b0, -8192);
      recv(e, 1'b0, $sformatf("fs%0d", i));
    end

    // Abort mid-MAC; delay lines and coefficients return to defaults
    send(1'b0, -8192);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort out_valid in rst", out_valid, 0);
    chk("abort in_ready in rst", in_ready, 0);
    reset = 1'b0;
    n = 0;
    repeat (24) begin @(negedge clk); if (out_valid) n++; end
    chk("abort no output", n, 0);
    send(1'b0, 100);
    recv(100, 1'b0, "post abort");

    // Invalid channel on a 3-channel, 4-tap instance
    e_in_valid = 1'b1; e_in_chan = 2'd3; e_in_data = 14'd77;
    @(negedge clk);
    e_in_valid = 1'b0;
    chk("err pulse", e_err_chan, 1);
    chk("err in_ready", e_in_ready, 1);
    @(negedge clk);
    chk("err one cycle", e_err_chan, 0);
    n = 0;
    repeat (8) begin if (e_out_valid) n++; @(negedge clk); end
    chk("err no output", n, 0);
    e_in_valid = 1'b1; e_in_chan = 2'd2; e_in_data = 14'd10;
    @(negedge clk);
    e_in_valid = 1'b0;
    t0 = cyc;
    n = 0;
    while (!e_out_valid && n < 100) begin @(negedge clk); n++; end
    chk("ch2 latency", cyc - t0, 4);
    chk("ch2 data", e_out_data, 10);
    chk("ch2 chan", e_out_chan, 2);
    chk("ch2 err quiet", e_err_chan, 0);
    e_out_ready = 1'b1;
    @(negedge clk);
    e_out_ready = 1'b0;
    chk("ch2 released", e_out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
